reservation_station: RTL and testbench

RESERVATION_STATION -- requirements
Module: reservation_station

---
 rtl/reservation_station.sv | 113 +++++++++++
 tb/tb_reservation_station.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// reservation_station: 4-entry operand-capturing station with single-issue ALU and registered result bus
module reservation_station (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  op_in,
   input  logic [31:0] value1_in,
   input  logic [31:0] value2_in,
   input  logic [2:0]  query1_in,
   input  logic [2:0]  query2_in,
   input  logic [2:0]  target_in,
   input  logic [2:0]  mem_num,
   input  logic [31:0] mem_value,
   output logic        rs_full,
   output logic [2:0]  alu_num,
   output logic [31:0] alu_value
);
   logic [3:0]  valid;
   logic [4:0]  op [4];
   logic [31:0] v1 [4];
   logic [31:0] v2 [4];
   logic [2:0]  q1 [4];
   logic [2:0]  q2 [4];
   logic [2:0]  tag [4];
   logic [3:0]  valid_next;
   logic [1:0]  issue_idx, disp_idx;
   logic        issue_en, disp_en, op_ok;
   logic [31:0] a, b, result;

   // A pending operand picks up a broadcast value; memory wins when both buses carry the tag.
   function automatic logic [34:0] resolve(input logic [2:0] q, input logic [31:0] v);
      if (q != 3'd0 && q == mem_num) return {3'd0, mem_value};
      if (q != 3'd0 && q == alu_num) return {3'd0, alu_value};
      return {q, v};
   endfunction

   // Opcode filter: only the supported encodings allocate an entry.
   always_comb begin
      case (op_in)
         5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
         5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b01010, 5'b01011,
         5'b01100, 5'b01101, 5'b10001, 5'b11010, 5'b11011: op_ok = 1'b1;
         default: op_ok = 1'b0;
      endcase
   end

   // Lowest-index ready entry issues; lowest-index slot free at cycle start takes a dispatch.
   always_comb begin
      issue_en  = 1'b0;
      issue_idx = 2'd0;
      disp_idx  = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (valid[i] && q1[i] == 3'd0 && q2[i] == 3'd0) begin
            issue_en  = 1'b1;
            issue_idx = 2'(i);
         end
         if (!valid[i]) disp_idx = 2'(i);
      end
      disp_en    = op_ok && valid != 4'hF;
      valid_next = (valid & ~(issue_en ? 4'b0001 << issue_idx : 4'b0000))
                 | (disp_en ? 4'b0001 << disp_idx : 4'b0000);
   end

   // ALU for the issuing entry; branches yield 1 when taken.
   always_comb begin
      a = v1[issue_idx];
      b = v2[issue_idx];
      case (op[issue_idx])
         5'b00000: result = a + b;
         5'b00001: result = a & b;
         5'b00010: result = a | b;
         5'b00011: result = a << b[4:0];
         5'b00100: result = a >> b[4:0];
         5'b00101: result = {31'd0, $signed(a) < $signed(b)};
         5'b00110: result = {31'd0, a < b};
         5'b00111: result = 32'($signed(a) >>> b[4:0]);
         5'b01000: result = a - b;
         5'b01001: result = a ^ b;
         5'b01010: result = {31'd0, a == b};
         5'b01011: result = {31'd0, $signed(a) >= $signed(b)};
         5'b01100: result = {31'd0, a != b};
         5'b01101: result = {31'd0, a >= b};
         5'b10001: result = (a + b) & 32'hFFFF_FFFE;
         5'b11010: result = {31'd0, $signed(a) < $signed(b)};
         5'b11011: result = {31'd0, a < b};
         default:  result = 32'd0;
      endcase
   end

   // Entry state, wakeup, dispatch write, result register and full flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid     <= 4'd0;
         alu_num   <= 3'd0;
         alu_value <= 32'd0;
         rs_full   <= 1'b0;
      end else begin
         valid   <= valid_next;
         rs_full <= $countones(valid_next) >= 3;
         alu_num <= issue_en ? tag[issue_idx] : 3'd0;
         if (issue_en) alu_value <= result;
         for (int i = 0; i < 4; i++) begin
            {q1[i], v1[i]} <= resolve(q1[i], v1[i]);
            {q2[i], v2[i]} <= resolve(q2[i], v2[i]);
         end
         if (disp_en) begin
            op[disp_idx]               <= op_in;
            tag[disp_idx]              <= target_in;
            {q1[disp_idx], v1[disp_idx]} <= resolve(query1_in, value1_in);
            {q2[disp_idx], v2[disp_idx]} <= resolve(query2_in, value2_in);
         end
      end
   end
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed vector and sequence checks for reservation_station
module tb_reservation_station;
   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  op_in;
   logic [31:0] value1_in, value2_in, mem_value;
   logic [2:0]  query1_in, query2_in, target_in, mem_num;
   logic        rs_full;
   logic [2:0]  alu_num;
   logic [31:0] alu_value;
   int total = 0;
   int bad = 0;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      logic        acc;
   } vec_t;
   vec_t vecs [18];

   reservation_station dut (
      .clk(clk), .rst(rst), .op_in(op_in), .value1_in(value1_in), .value2_in(value2_in),
      .query1_in(query1_in), .query2_in(query2_in), .target_in(target_in),
      .mem_num(mem_num), .mem_value(mem_value), .rs_full(rs_full),
      .alu_num(alu_num), .alu_value(alu_value)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [2:0] qa, input logic [2:0] qb, input logic [2:0] t,
                        input logic [2:0] mn, input logic [31:0] mv);
      op_in = o; value1_in = x; value2_in = y; query1_in = qa; query2_in = qb;
      target_in = t; mem_num = mn; mem_value = mv;
      tick();
   endtask

   task automatic idle();
      drive(5'b11111, 32'd0, 32'd0, 3'd0, 3'd0, 3'd1, 3'd0, 32'd0);
   endtask

   initial begin
      vecs[0]  = '{5'b00000, 32'd5,          32'd7,          32'd12,         1'b1};
      vecs[1]  = '{5'b01000, 32'd1,          32'd2,          32'hFFFF_FFFF,  1'b1};
      vecs[2]  = '{5'b00001, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1'b1};
      vecs[3]  = '{5'b00010, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_FFF0,  1'b1};
      vecs[4]  = '{5'b01001, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_0FF0,  1'b1};
      vecs[5]  = '{5'b00011, 32'd1,          32'd33,         32'd2,          1'b1};
      vecs[6]  = '{5'b00100, 32'h8000_0000,  32'd4,          32'h0800_0000,  1'b1};
      vecs[7]  = '{5'b00111, 32'h8000_0000,  32'd4,          32'hF800_0000,  1'b1};
      vecs[8]  = '{5'b00101, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b1};
      vecs[9]  = '{5'b00110, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};
      vecs[10] = '{5'b01010, 32'd5,          32'd5,          32'd1,          1'b1};
      vecs[11] = '{5'b01100, 32'd5,          32'd5,          32'd0,          1'b1};
      vecs[12] = '{5'b01011, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};
      vecs[13] = '{5'b01101, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b1};
      vecs[14] = '{5'b11011, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};
      vecs[15] = '{5'b11010, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b1};
      vecs[16] = '{5'b10001, 32'h0000_1001,  32'd4,          32'h0000_1004,  1'b1};
      vecs[17] = '{5'b01110, 32'd9,          32'd9,          32'd0,          1'b0};

      rst = 1'b1;
      idle();
      idle();
      chk("reset alu_num", 32'(alu_num), 32'd0);
      chk("reset alu_value", alu_value, 32'd0);
      chk("reset rs_full", 32'(rs_full), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 18; i++) begin
         logic [2:0] t;
         t = 3'(i % 7 + 1);
         drive(vecs[i].op, vecs[i].a, vecs[i].b, 3'd0, 3'd0, t, 3'd0, 32'd0);
         chk($sformatf("vec%0d early num", i), 32'(alu_num), 32'd0);
         idle();
         chk($sformatf("vec%0d num", i), 32'(alu_num), vecs[i].acc ? 32'(t) : 32'd0);
         if (vecs[i].acc) chk($sformatf("vec%0d value", i), alu_value, vecs[i].exp);
         idle();
         chk($sformatf("vec%0d after num", i), 32'(alu_num), 32'd0);
      end

      drive(5'b01000, 32'hDEAD, 32'd1, 3'd4, 3'd0, 3'd2, 3'd0, 32'd0);
      idle();
      chk("wake waiting num", 32'(alu_num), 32'd0);
      drive(5'b11111, 32'd0, 32'd0, 3'd0, 3'd0, 3'd1, 3'd4, 32'd10);
      chk("wake capture num", 32'(alu_num), 32'd0);
      idle();
      chk("wake num", 32'(alu_num), 32'd2);
      chk("wake value", alu_value, 32'd9);

      for (int i = 1; i <= 4; i++) begin
         drive(5'b00000, 32'hBAD, 32'(i), 3'd5, 3'd0, 3'(i), 3'd0, 32'd0);
         chk($sformatf("fill%0d rs_full", i), 32'(rs_full), i >= 3 ? 32'd1 : 32'd0);
      end
      drive(5'b00000, 32'd100, 32'd0, 3'd0, 3'd0, 3'd6, 3'd0, 32'd0);
      chk("drop rs_full", 32'(rs_full), 32'd1);
      idle();
      chk("drop no issue", 32'(alu_num), 32'd0);
      drive(5'b11111, 32'd0, 32'd0, 3'd0, 3'd0, 3'd1, 3'd5, 32'd10);
      chk("drain wake num", 32'(alu_num), 32'd0);
      for (int i = 1; i <= 4; i++) begin
         idle();
         chk($sformatf("drain%0d num", i), 32'(alu_num), 32'(i));
         chk($sformatf("drain%0d value", i), alu_value, 32'(10 + i));
         chk($sformatf("drain%0d rs_full", i), 32'(rs_full), i == 1 ? 32'd1 : 32'd0);
      end
      idle();
      chk("drain end num", 32'(alu_num), 32'd0);

      drive(5'b00000, 32'd20, 32'd3, 3'd0, 3'd0, 3'd1, 3'd0, 32'd0);
      idle();
      chk("fwd alu src num", 32'(alu_num), 32'd1);
      drive(5'b00000, 32'd0, 32'd100, 3'd1, 3'd0, 3'd2, 3'd0, 32'd0);
      idle();
      chk("fwd alu num", 32'(alu_num), 32'd2);
      chk("fwd alu value", alu_value, 32'd123);
      drive(5'b00000, 32'd7, 32'd0, 3'd0, 3'd0, 3'd3, 3'd0, 32'd0);
      idle();
      chk("fwd both src num", 32'(alu_num), 32'd3);
      drive(5'b00000, 32'd0, 32'd1, 3'd3, 3'd0, 3'd4, 3'd3, 32'd50);
      idle();
      chk("fwd mem wins num", 32'(alu_num), 32'd4);
      chk("fwd mem wins value", alu_value, 32'd51);

      drive(5'b00000, 32'd0, 32'd1, 3'd6, 3'd0, 3'd2, 3'd0, 32'd0);
      drive(5'b00000, 32'd0, 32'd1, 3'd6, 3'd0, 3'd3, 3'd0, 32'd0);
      drive(5'b00000, 32'd1, 32'd1, 3'd0, 3'd0, 3'd1, 3'd0, 32'd0);
      idle();
      chk("pre-reset bus", 32'(alu_num), 32'd1);
      rst = 1'b1;
      drive(5'b00000, 32'd8, 32'd8, 3'd0, 3'd0, 3'd5, 3'd0, 32'd0);
      rst = 1'b0;
      chk("mid reset num", 32'(alu_num), 32'd0);
      chk("mid reset value", alu_value, 32'd0);
      chk("mid reset rs_full", 32'(rs_full), 32'd0);
      drive(5'b00000, 32'd2, 32'd3, 3'd0, 3'd0, 3'd7, 3'd6, 32'd40);
      chk("post reset quiet", 32'(alu_num), 32'd0);
      idle();
      chk("post reset first num", 32'(alu_num), 32'd7);
      chk("post reset first value", alu_value, 32'd5);
      for (int i = 0; i < 3; i++) begin
         idle();
         chk($sformatf("no stale %0d", i), 32'(alu_num), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
